ecc_err_monitor: RTL and testbench

ECC_ERR_MONITOR -- requirements
Module: ecc_err_monitor

---
 rtl/ecc_err_monitor_if.sv | 29 ++
 rtl/ecc_err_monitor.sv | 125 ++++++++++++
 tb/tb_ecc_err_monitor.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ecc_err_monitor_if.sv
// Decoded-word input bus and scrub write-back bus of the ECC error monitor.
// master = decoder/memory side, slave = the monitor.
interface ecc_err_monitor_if #(
    parameter int AW = 16
);
    logic          valid;
    logic          in_ready;
    logic [AW-1:0] addr;
    logic [38:0]   data;
    logic [6:0]    syn;
    logic          err;
    logic          sgl;
    logic          dbl;

    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_addr;
    logic [38:0]   wb_data;

    modport master (
        output valid, addr, data, syn, err, sgl, dbl, wb_ready,
        input  in_ready, wb_valid, wb_addr, wb_data
    );

    modport slave (
        input  valid, addr, data, syn, err, sgl, dbl, wb_ready,
        output in_ready, wb_valid, wb_addr, wb_data
    );
endinterface

// File: rtl/ecc_err_monitor.sv
// ECC error monitor: counts SEC/DED events, logs the first error, raises a
// sticky IRQ and issues a scrub write-back for every correctable word.
//
// state | meaning
// IDLE  | accepting decoded words (in_ready=1)
// WB    | holding a corrected word on the write-back port until wb_ready
module ecc_err_monitor #(
    parameter int AW      = 16,
    parameter int CW      = 16,
    parameter int SEC_THR = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    ecc_err_monitor_if.slave    bus,
    input  logic                clr,
    output logic [CW-1:0]       sec_cnt,
    output logic [CW-1:0]       ded_cnt,
    output logic                log_valid,
    output logic                log_dbl,
    output logic [6:0]          log_syn,
    output logic [AW-1:0]       log_addr,
    output logic                irq
);

    typedef enum logic {IDLE = 1'b0, WB = 1'b1} state_t;

    localparam logic [CW-1:0] SEC_THR_C = CW'(SEC_THR);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

    state_t        state_q, state_d;
    logic [AW-1:0] wb_addr_q;
    logic [38:0]   wb_data_q;
    logic          accept;
    logic          sgl_beat;
    logic          dbl_beat;

    // A beat carrying both flags is uncorrectable; err=0 means a clean word.
    assign accept   = bus.valid && (state_q == IDLE);
    assign dbl_beat = accept && bus.err && bus.dbl;
    assign sgl_beat = accept && bus.err && bus.sgl && !bus.dbl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sgl_beat)     state_d = WB;
            WB:      if (bus.wb_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = 1'b0;
        bus.wb_valid = 1'b0;
        case (state_q)
            IDLE:    bus.in_ready = 1'b1;
            WB:      bus.wb_valid = 1'b1;
            default: bus.in_ready = 1'b0;
        endcase
    end

    assign bus.wb_addr = wb_addr_q;
    assign bus.wb_data = wb_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else if (sgl_beat) begin
            wb_addr_q <= bus.addr;
            wb_data_q <= bus.data;
        end
    end

    // clr wins over an error accepted in the same cycle; the write-back above
    // is deliberately independent of clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else if (clr) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else begin
            if (sgl_beat && (sec_cnt != CNT_MAX)) sec_cnt <= sec_cnt + 1'b1;
            if (dbl_beat && (ded_cnt != CNT_MAX)) ded_cnt <= ded_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log_valid <= 1'b0;
            log_dbl   <= 1'b0;
            log_syn   <= '0;
            log_addr  <= '0;
        end else if (clr) begin
            log_valid <= 1'b0;
        end else if (!log_valid && (sgl_beat || dbl_beat)) begin
            log_valid <= 1'b1;
            log_dbl   <= dbl_beat;
            log_syn   <= bus.syn;
            log_addr  <= bus.addr;
        end
    end

    // Threshold is judged on the registered count, so irq follows one cycle
    // after the count reaches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else if (clr) begin
            irq <= 1'b0;
        end else if (dbl_beat || (sec_cnt >= SEC_THR_C)) begin
            irq <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ecc_err_monitor.sv
// Directed bench for ecc_err_monitor: write-back handshake, counters, log,
// IRQ, clear and reset behaviour, plus saturation on a narrow-counter copy.
module tb_ecc_err_monitor;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [15:0] sec_cnt, ded_cnt;
    logic        log_valid, log_dbl, irq;
    logic [6:0]  log_syn;
    logic [15:0] log_addr;

    logic        clr2;
    logic [3:0]  sec_cnt2, ded_cnt2;
    logic        log_valid2, log_dbl2, irq2;
    logic [6:0]  log_syn2;
    logic [15:0] log_addr2;

    int errors = 0;
    int checks = 0;

    ecc_err_monitor_if #(.AW(16)) bus  ();
    ecc_err_monitor_if #(.AW(16)) bus2 ();

    ecc_err_monitor #(.AW(16), .CW(16), .SEC_THR(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .clr(clr),
        .sec_cnt(sec_cnt), .ded_cnt(ded_cnt), .log_valid(log_valid),
        .log_dbl(log_dbl), .log_syn(log_syn), .log_addr(log_addr), .irq(irq)
    );

    ecc_err_monitor #(.AW(16), .CW(4), .SEC_THR(8)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave), .clr(clr2),
        .sec_cnt(sec_cnt2), .ded_cnt(ded_cnt2), .log_valid(log_valid2),
        .log_dbl(log_dbl2), .log_syn(log_syn2), .log_addr(log_addr2), .irq(irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [15:0] a, input logic [38:0] d,
                              input logic [6:0] s, input logic e,
                              input logic sg, input logic db);
        bus.addr  = a;
        bus.data  = d;
        bus.syn   = s;
        bus.err   = e;
        bus.sgl   = sg;
        bus.dbl   = db;
        bus.valid = 1'b1;
    endtask

    task automatic clear_all();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr = 1'b0; clr2 = 1'b0;
        bus.valid = 0; bus.addr = 0; bus.data = 0; bus.syn = 0;
        bus.err = 0; bus.sgl = 0; bus.dbl = 0; bus.wb_ready = 0;
        bus2.valid = 0; bus2.addr = 0; bus2.data = 0; bus2.syn = 0;
        bus2.err = 0; bus2.sgl = 0; bus2.dbl = 0; bus2.wb_ready = 0;
        repeat (2) tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %b want 0", bus.wb_valid); end
        checks++; if (bus.wb_addr !== 16'h0) begin errors++; $display("FAIL rst_wb_addr: got %h want 0", bus.wb_addr); end
        checks++; if (sec_cnt !== 16'h0 || ded_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt: got %h/%h want 0/0", sec_cnt, ded_cnt); end
        checks++; if (log_valid !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL rst_log_irq: got %b/%b want 0/0", log_valid, irq); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sgl_writeback();
        drive_beat(16'h0012, 39'h12_3456_789A, 7'h15, 1'b1, 1'b1, 1'b0);
        tick();
        // Source offers a DBL word while the block is busy; it must be ignored.
        drive_beat(16'h0099, 39'h0, 7'h7E, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL sgl_wb_valid[%0d]: got %b want 1", i, bus.wb_valid); end
            checks++; if (bus.wb_addr !== 16'h0012) begin errors++; $display("FAIL sgl_wb_addr[%0d]: got %h want 0012", i, bus.wb_addr); end
            checks++; if (bus.wb_data !== 39'h12_3456_789A) begin errors++; $display("FAIL sgl_wb_data[%0d]: got %h want 123456789a", i, bus.wb_data); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL sgl_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
            bus.wb_ready = (i == 3);
            if (i == 3) bus.valid = 1'b0;
            tick();
        end
        bus.wb_ready = 1'b0;
        checks++; if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL sgl_release: got wb_valid=%b in_ready=%b want 0/1", bus.wb_valid, bus.in_ready); end
        checks++; if (sec_cnt !== 16'd1) begin errors++; $display("FAIL sgl_sec_cnt: got %0d want 1", sec_cnt); end
        checks++; if (ded_cnt !== 16'd0) begin errors++; $display("FAIL sgl_ignored_beat: got ded_cnt=%0d want 0", ded_cnt); end
        checks++; if (log_valid !== 1'b1 || log_dbl !== 1'b0) begin errors++; $display("FAIL sgl_log_flags: got %b/%b want 1/0", log_valid, log_dbl); end
        checks++; if (log_addr !== 16'h0012 || log_syn !== 7'h15) begin errors++; $display("FAIL sgl_log_fields: got %h/%h want 0012/15", log_addr, log_syn); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL sgl_irq: got %b want 0", irq); end
    endtask

    task automatic test_dbl();
        clear_all();
        drive_beat(16'h0040, 39'h1, 7'h03, 1'b1, 1'b0, 1'b1);
        tick();
        bus.valid = 1'b0;
        checks++; if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL dbl_no_wb: got wb_valid=%b in_ready=%b want 0/1", bus.wb_valid, bus.in_ready); end
        checks++; if (ded_cnt !== 16'd1) begin errors++; $display("FAIL dbl_ded_cnt: got %0d want 1", ded_cnt); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL dbl_irq: got %b want 1", irq); end
        checks++; if (log_valid !== 1'b1 || log_dbl !== 1'b1 || log_syn !== 7'h03 || log_addr !== 16'h0040) begin errors++; $display("FAIL dbl_log: got v=%b d=%b syn=%h addr=%h want 1/1/03/0040", log_valid, log_dbl, log_syn, log_addr); end
        drive_beat(16'h0041, 39'h2, 7'h7F, 1'b1, 1'b1, 1'b1);
        tick();
        bus.valid = 1'b0;
        checks++; if (bus.wb_valid !== 1'b0 || ded_cnt !== 16'd2 || sec_cnt !== 16'd0) begin errors++; $display("FAIL illegal_flags: got wb_valid=%b ded=%0d sec=%0d want 0/2/0", bus.wb_valid, ded_cnt, sec_cnt); end
        checks++; if (log_syn !== 7'h03 || log_addr !== 16'h0040) begin errors++; $display("FAIL log_sticky: got %h/%h want 03/0040", log_syn, log_addr); end
        drive_beat(16'h0042, 39'h3, 7'h00, 1'b0, 1'b1, 1'b0);
        tick();
        bus.valid = 1'b0;
        checks++; if (bus.wb_valid !== 1'b0 || sec_cnt !== 16'd0 || ded_cnt !== 16'd2) begin errors++; $display("FAIL clean_beat: got wb_valid=%b sec=%0d ded=%0d want 0/0/2", bus.wb_valid, sec_cnt, ded_cnt); end
        clear_all();
        checks++; if (irq !== 1'b0 || log_valid !== 1'b0 || ded_cnt !== 16'd0) begin errors++; $display("FAIL dbl_clr: got irq=%b log_valid=%b ded=%0d want 0/0/0", irq, log_valid, ded_cnt); end
    endtask

    task automatic test_threshold();
        for (int i = 0; i < 8; i++) begin
            drive_beat(16'h0100 + 16'(i), 39'(i), 7'(i + 1), 1'b1, 1'b1, 1'b0);
            tick();
            bus.valid = 1'b0;
            checks++; if (bus.wb_addr !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL thr_wb_addr[%0d]: got %h want %h", i, bus.wb_addr, 16'h0100 + 16'(i)); end
            checks++; if (sec_cnt !== 16'(i + 1) || irq !== 1'b0) begin errors++; $display("FAIL thr_count[%0d]: got sec=%0d irq=%b want %0d/0", i, sec_cnt, irq, i + 1); end
            bus.wb_ready = 1'b1;
            tick();
            bus.wb_ready = 1'b0;
            checks++; if (irq !== (i == 7)) begin errors++; $display("FAIL thr_irq[%0d]: got %b want %b", i, irq, (i == 7)); end
        end
        checks++; if (log_addr !== 16'h0100 || log_syn !== 7'h01 || log_dbl !== 1'b0) begin errors++; $display("FAIL thr_log: got addr=%h syn=%h dbl=%b want 0100/01/0", log_addr, log_syn, log_dbl); end
    endtask

    task automatic test_back_to_back();
        clear_all();
        drive_beat(16'h0200, 39'hA, 7'h11, 1'b1, 1'b1, 1'b0);
        bus.wb_ready = 1'b1;
        tick();
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 16'h0200 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_first: got v=%b addr=%h rdy=%b want 1/0200/0", bus.wb_valid, bus.wb_addr, bus.in_ready); end
        bus.addr = 16'h0201;
        bus.data = 39'hB;
        tick();
        checks++; if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_gap: got v=%b rdy=%b want 0/1", bus.wb_valid, bus.in_ready); end
        tick();
        bus.valid = 1'b0;
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 16'h0201 || bus.wb_data !== 39'hB) begin errors++; $display("FAIL b2b_second: got v=%b addr=%h data=%h want 1/0201/b", bus.wb_valid, bus.wb_addr, bus.wb_data); end
        tick();
        bus.wb_ready = 1'b0;
        checks++; if (sec_cnt !== 16'd2 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got sec=%0d v=%b want 2/0", sec_cnt, bus.wb_valid); end
    endtask

    task automatic test_clr_reset();
        drive_beat(16'h0055, 39'h55, 7'h22, 1'b1, 1'b1, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        bus.valid = 1'b0;
        checks++; if (sec_cnt !== 16'd0 || log_valid !== 1'b0) begin errors++; $display("FAIL clr_priority: got sec=%0d log_valid=%b want 0/0", sec_cnt, log_valid); end
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 16'h0055) begin errors++; $display("FAIL clr_wb: got v=%b addr=%h want 1/0055", bus.wb_valid, bus.wb_addr); end
        clear_all();
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 16'h0055) begin errors++; $display("FAIL clr_in_wb: got v=%b addr=%h want 1/0055", bus.wb_valid, bus.wb_addr); end
        rst_n = 1'b0;
        #2;
        checks++; if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_abort: got v=%b rdy=%b want 0/1", bus.wb_valid, bus.in_ready); end
        checks++; if (bus.wb_addr !== 16'h0 || bus.wb_data !== 39'h0) begin errors++; $display("FAIL rst_abort_regs: got %h/%h want 0/0", bus.wb_addr, bus.wb_data); end
        rst_n = 1'b1;
        drive_beat(16'h0066, 39'h66, 7'h33, 1'b1, 1'b1, 1'b0);
        tick();
        bus.valid = 1'b0;
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 16'h0066 || sec_cnt !== 16'd1) begin errors++; $display("FAIL rst_first_edge: got v=%b addr=%h sec=%0d want 1/0066/1", bus.wb_valid, bus.wb_addr, sec_cnt); end
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready = 1'b0;
    endtask

    task automatic test_saturation();
        bus2.err   = 1'b1;
        bus2.dbl   = 1'b1;
        bus2.valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus2.addr = 16'(i);
            tick();
            checks++; if (ded_cnt2 !== ((i < 15) ? 4'(i + 1) : 4'd15)) begin errors++; $display("FAIL sat_ded[%0d]: got %0d want %0d", i, ded_cnt2, (i < 15) ? i + 1 : 15); end
        end
        bus2.valid = 1'b0;
        checks++; if (sec_cnt2 !== 4'd0 || log_addr2 !== 16'h0 || irq2 !== 1'b1) begin errors++; $display("FAIL sat_other: got sec=%0d addr=%h irq=%b want 0/0000/1", sec_cnt2, log_addr2, irq2); end
    endtask

    initial begin
        test_reset();
        test_sgl_writeback();
        test_dbl();
        test_threshold();
        test_back_to_back();
        test_clr_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
